// File: rtl/bcd_to_float.sv
// Four-digit BCD to IEEE754 single-precision converter using reverse double-dabble.
// Optional invalid-digit detection is enabled with macro BCD_TO_FLOAT_DIGIT_CHECK_EN.
module bcd_to_float (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_in,
    input  logic [15:0] bcd_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] float_out,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        NORM,
        OUT
    } state_t;

    state_t      state_q;
    logic [29:0] sr_q;
    logic [29:0] sr_d;
    logic        sign_q;
    logic [3:0]  cnt_q;
    logic [3:0]  k_q;
    logic [31:0] float_q;
    logic        valid_q;
    logic [7:0]  exp_w;
    logic        norm_done;

`ifdef BCD_TO_FLOAT_DIGIT_CHECK_EN
    logic        err_q;
    logic        bad_digit;

    // Any latched digit above 9 marks the operand as invalid
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (sr_q[14+4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // One reverse double-dabble step: shift right, then correct digits >= 8
    always_comb begin
        sr_d = sr_q >> 1;
        for (int i = 0; i < 4; i++) begin
            if (sr_d[14+4*i +: 4] >= 4'd8) begin
                sr_d[14+4*i +: 4] = sr_d[14+4*i +: 4] - 4'd3;
            end
        end
    end

    assign exp_w     = 8'd140 - {4'd0, k_q};
    assign norm_done = sr_q[13] || (sr_q[13:0] == 14'd0);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = valid_q;
    assign float_out = float_q;

    // Control FSM with registered result, error and valid outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            float_q <= 32'd0;
            cnt_q   <= 4'd0;
            k_q     <= 4'd0;
`ifdef BCD_TO_FLOAT_DIGIT_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sr_q    <= {bcd_in, 14'd0};
                        sign_q  <= sign_in;
                        cnt_q   <= 4'd0;
                        k_q     <= 4'd0;
                        state_q <= CONV;
                    end
                end
                CONV: begin
`ifdef BCD_TO_FLOAT_DIGIT_CHECK_EN
                    if (cnt_q == 4'd0 && bad_digit) begin
                        float_q <= 32'h7FC00000;
                        err_q   <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= OUT;
                    end else begin
`else
                    begin
`endif
                        sr_q  <= sr_d;
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'd13) begin
                            state_q <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (norm_done) begin
                        if (sr_q[13:0] == 14'd0) begin
                            float_q <= 32'd0;
                        end else begin
                            float_q <= {sign_q, exp_w,
                                        sr_q[12:0], 10'd0};
                        end
`ifdef BCD_TO_FLOAT_DIGIT_CHECK_EN
                        err_q   <= 1'b0;
`endif
                        valid_q <= 1'b1;
                        state_q <= OUT;
                    end else begin
                        sr_q[13:0] <= {sr_q[12:0], 1'b0};
                        k_q        <= k_q + 4'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_float.sv
// Directed scoreboard bench for bcd_to_float.
// Expected floats come from an arithmetic model of the BCD value.
module tb_bcd_to_float;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign_in = 1'b0;
    logic [15:0] bcd_in = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] float_out;
    logic        err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] f;
        logic        e;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    bcd_to_float dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in   (sign_in),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .float_out (float_out),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [15:0] b, input logic s);
        exp_t r;
        int v;
        int msb;
        v = b[15:12] * 1000 + b[11:8] * 100 + b[7:4] * 10 + b[3:0];
        r.e = 1'b0;
        if (v == 0) begin
            r.f = 32'd0;
            r.lat = 15;
        end else begin
            msb = 0;
            for (int i = 0; i < 14; i++) if (v >= (1 << i)) msb = i;
            r.f = {s, 8'(127 + msb), 23'((v << (23 - msb)) & 32'h7FFFFF)};
            r.lat = 15 + 13 - msb;
        end
        return r;
    endfunction

    task automatic send(input logic [15:0] b, input logic s);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        bcd_in = b;
        sign_in = s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        bcd_in = 16'hFFFF;
        sign_in = ~s;
    endtask

    task automatic receive(input string tag, input int hold);
        exp_t x;
        int cyc;
        logic [31:0] f0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        x = sb.pop_front();
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_lat"}, cyc, x.lat);
        check({tag, "_float"}, float_out, x.f);
        check({tag, "_err"}, {31'd0, err}, {31'd0, x.e});
        f0 = float_out;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_float"}, float_out, f0);
            check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_hold_inrdy"}, {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_inrdy_after"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic op(input string tag, input logic [15:0] b,
                      input logic s, input int hold);
        sb.push_back(model(b, s));
        send(b, s);
        receive(tag, hold);
    endtask

    initial begin
        exp_t x;
        int seen;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_float", float_out, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_inrdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;

        check("model_0001", model(16'h0001, 1'b0).f, 32'h3F800000);
        check("model_9999", model(16'h9999, 1'b0).f, 32'h461C3C00);
        check("model_1234", model(16'h1234, 1'b1).f, 32'hC49A4000);

        op("v0001", 16'h0001, 1'b0, 0);
        op("v9999", 16'h9999, 1'b0, 0);
        op("v1234", 16'h1234, 1'b1, 0);
        op("v0000n", 16'h0000, 1'b1, 5);
        op("v0512", 16'h0512, 1'b0, 1);
        op("v8192", 16'h8192, 1'b1, 0);

`ifdef BCD_TO_FLOAT_DIGIT_CHECK_EN
        x.f = 32'h7FC00000;
        x.e = 1'b1;
        x.lat = 1;
        sb.push_back(x);
        send(16'h00A0, 1'b0);
        receive("bad00A0", 2);
`else
        send(16'h00A0, 1'b0);
        seen = 0;
        for (int i = 0; i < 40 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        check("bad00A0_valid", {31'd0, out_valid}, 32'd1);
        check("bad00A0_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
`endif

        send(16'h0005, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_inrdy_t6", {31'd0, in_ready}, 32'd1);
        check("abort_valid_t6", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("abort_inrdy_t7", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_valid", seen, 0);
        op("v0002", 16'h0002, 1'b0, 0);
        check("v0002_direct", model(16'h0002, 1'b0).f, 32'h40000000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
